// File: rtl/sipo_deframer.sv
`default_nettype none
// ============================================================================
//  Module      : sipo_deframer
//  Description : Serial-in / parallel-out frame recovery. Rebuilds words from
//                an MSB-first serial stream, hunts bit-by-bit for SYNC_WORD,
//                confirms alignment over LOCK_COUNT sync slots, then delivers
//                each data word with a one-cycle strobe. Isolated sync errors
//                while locked are flywheeled over; MISS_LIMIT consecutive
//                errors force a fresh hunt.
//  Ports       : clk         - rising-edge clock
//                rst_n       - synchronous reset, ACTIVE HIGH (legacy name)
//                sin         - serial data, MSB of each word first
//                sin_en      - sin valid this cycle; nothing advances when low
//                dout        - last recovered data word (held between strobes)
//                dout_valid  - one-cycle strobe: dout carries a new data word
//                sync_pulse  - one-cycle strobe: sync slot matched SYNC_WORD
//                err_sync    - one-cycle strobe: sync slot mismatch while locked
//                locked      - frame alignment established
//  Revision    : 1.0 - initial release
// ============================================================================
module sipo_deframer #(
    parameter int                    DATA_WIDTH  = 4,
    parameter logic [DATA_WIDTH-1:0] SYNC_WORD   = 4'b1011,
    parameter int                    FRAME_WORDS = 3,
    parameter int                    LOCK_COUNT  = 2,
    parameter int                    MISS_LIMIT  = 2
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  sin,
    input  wire logic                  sin_en,
    output logic [DATA_WIDTH-1:0]      dout,
    output logic                       dout_valid,
    output logic                       sync_pulse,
    output logic                       err_sync,
    output logic                       locked
);

    localparam int c_bit_w  = $clog2(DATA_WIDTH);
    localparam int c_slot_w = $clog2(FRAME_WORDS + 1);
    localparam int c_good_w = $clog2(LOCK_COUNT + 1);
    localparam int c_miss_w = $clog2(MISS_LIMIT + 1);

    localparam logic [c_bit_w-1:0]  c_bit_last   = c_bit_w'(DATA_WIDTH - 1);
    localparam logic [c_slot_w-1:0] c_slot_last  = c_slot_w'(FRAME_WORDS);
    localparam logic [c_good_w-1:0] c_good_final = c_good_w'(LOCK_COUNT - 1);
    localparam logic [c_miss_w-1:0] c_miss_final = c_miss_w'(MISS_LIMIT - 1);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Only the W-1 most recent bits need storing: the incoming bit completes
    // the comparison window combinationally.
    state_t                  r_state;
    logic [DATA_WIDTH-2:0]   r_hist;
    logic [c_bit_w-1:0]      r_bit_cnt;
    logic [c_slot_w-1:0]     r_slot;
    logic [c_good_w-1:0]     r_good;
    logic [c_miss_w-1:0]     r_miss;
    logic [DATA_WIDTH-1:0]   r_dout;
    logic                    r_dout_valid;
    logic                    r_sync_pulse;
    logic                    r_err_sync;
    logic                    r_locked;

    state_t                  w_state_nxt;
    logic [DATA_WIDTH-2:0]   w_hist_nxt;
    logic [c_bit_w-1:0]      w_bit_nxt;
    logic [c_slot_w-1:0]     w_slot_nxt;
    logic [c_good_w-1:0]     w_good_nxt;
    logic [c_miss_w-1:0]     w_miss_nxt;
    logic [DATA_WIDTH-1:0]   w_dout_nxt;
    logic                    w_dv_nxt;
    logic                    w_sp_nxt;
    logic                    w_err_nxt;

    logic [DATA_WIDTH-1:0]   w_window;
    logic                    w_match;
    logic                    w_word_end;
    logic                    w_sync_slot;

    assign w_window    = {r_hist, sin};
    assign w_match     = (w_window == SYNC_WORD);
    assign w_word_end  = (r_bit_cnt == c_bit_last);
    assign w_sync_slot = (r_slot == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_hist_nxt  = r_hist;
        w_bit_nxt   = r_bit_cnt;
        w_slot_nxt  = r_slot;
        w_good_nxt  = r_good;
        w_miss_nxt  = r_miss;
        w_dout_nxt  = r_dout;
        w_dv_nxt    = 1'b0;
        w_sp_nxt    = 1'b0;
        w_err_nxt   = 1'b0;

        if (sin_en) begin
            w_hist_nxt = w_window[DATA_WIDTH-2:0];

            // Word/slot tracking only runs once an alignment candidate exists.
            if (r_state != ST_HUNT) begin
                if (w_word_end) begin
                    w_bit_nxt  = '0;
                    w_slot_nxt = (r_slot == c_slot_last) ? '0 : r_slot + c_slot_w'(1);
                end else begin
                    w_bit_nxt  = r_bit_cnt + c_bit_w'(1);
                end
            end

            case (r_state)
                ST_HUNT: begin
                    // Bit-granular search: the hit defines the new word grid,
                    // so the next accepted bit is bit 0 of data slot 1.
                    if (w_match) begin
                        w_sp_nxt   = 1'b1;
                        w_bit_nxt  = '0;
                        w_slot_nxt = c_slot_w'(1);
                        w_good_nxt = c_good_w'(1);
                        w_miss_nxt = '0;
                        w_state_nxt = (LOCK_COUNT == 1) ? ST_LOCKED : ST_VERIFY;
                    end
                end

                ST_VERIFY: begin
                    if (w_word_end && w_sync_slot) begin
                        if (w_match) begin
                            w_sp_nxt   = 1'b1;
                            w_good_nxt = r_good + c_good_w'(1);
                            if (r_good == c_good_final) begin
                                w_state_nxt = ST_LOCKED;
                                w_miss_nxt  = '0;
                            end
                        end else begin
                            w_state_nxt = ST_HUNT;
                            w_bit_nxt   = '0;
                            w_slot_nxt  = '0;
                            w_good_nxt  = '0;
                            w_miss_nxt  = '0;
                        end
                    end
                end

                ST_LOCKED: begin
                    if (w_word_end) begin
                        if (!w_sync_slot) begin
                            w_dout_nxt = w_window;
                            w_dv_nxt   = 1'b1;
                        end else if (w_match) begin
                            w_sp_nxt   = 1'b1;
                            w_miss_nxt = '0;
                        end else begin
                            w_err_nxt = 1'b1;
                            if (r_miss == c_miss_final) begin
                                w_state_nxt = ST_HUNT;
                                w_bit_nxt   = '0;
                                w_slot_nxt  = '0;
                                w_good_nxt  = '0;
                                w_miss_nxt  = '0;
                            end else begin
                                // Flywheel: keep the old alignment.
                                w_miss_nxt = r_miss + c_miss_w'(1);
                            end
                        end
                    end
                end

                default: begin
                    w_state_nxt = ST_HUNT;
                    w_bit_nxt   = '0;
                    w_slot_nxt  = '0;
                    w_good_nxt  = '0;
                    w_miss_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state      <= ST_HUNT;
            r_hist       <= '0;
            r_bit_cnt    <= '0;
            r_slot       <= '0;
            r_good       <= '0;
            r_miss       <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_sync_pulse <= 1'b0;
            r_err_sync   <= 1'b0;
            r_locked     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_hist       <= w_hist_nxt;
            r_bit_cnt    <= w_bit_nxt;
            r_slot       <= w_slot_nxt;
            r_good       <= w_good_nxt;
            r_miss       <= w_miss_nxt;
            r_dout       <= w_dout_nxt;
            r_dout_valid <= w_dv_nxt;
            r_sync_pulse <= w_sp_nxt;
            r_err_sync   <= w_err_nxt;
            // Registered decode of the next state, so locked tracks r_state.
            r_locked     <= (w_state_nxt == ST_LOCKED);
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign sync_pulse = r_sync_pulse;
    assign err_sync   = r_err_sync;
    assign locked     = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_sipo_deframer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sipo_deframer
//  Description : Directed self-checking bench for sipo_deframer with
//                DATA_WIDTH=4, SYNC=1011, FRAME_WORDS=3, LOCK_COUNT=2,
//                MISS_LIMIT=2. Status vectors are {early,sp,dv,err,locked},
//                where early flags any strobe outside a word's last bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sipo_deframer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sin;
    logic       sin_en;
    logic [3:0] dout;
    logic       dout_valid;
    logic       sync_pulse;
    logic       err_sync;
    logic       locked;

    int checks = 0;
    int errors = 0;

    logic       mon_early;
    logic       mon_sp;
    logic       mon_dv;
    logic       mon_err;
    logic       mon_locked;
    logic [3:0] mon_dout;
    logic [4:0] got;
    logic [4:0] exp;

    sipo_deframer #(
        .DATA_WIDTH  (4),
        .SYNC_WORD   (4'b1011),
        .FRAME_WORDS (3),
        .LOCK_COUNT  (2),
        .MISS_LIMIT  (2)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sin        (sin),
        .sin_en     (sin_en),
        .dout       (dout),
        .dout_valid (dout_valid),
        .sync_pulse (sync_pulse),
        .err_sync   (err_sync),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    task automatic step(input logic b, input logic en);
        sin    = b;
        sin_en = en;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n  = 1'b1;
        sin_en = 1'b0;
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
    endtask

    // Sends one word MSB first, optionally with an idle (sin_en=0) cycle after
    // every accepted bit, and records what the outputs did.
    task automatic send_word(input logic [3:0] w, input bit toggle);
        mon_early = 1'b0;
        mon_sp    = 1'b0;
        mon_dv    = 1'b0;
        mon_err   = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            step(w[i], 1'b1);
            if (i != 0) begin
                if (sync_pulse | dout_valid | err_sync) mon_early = 1'b1;
            end else begin
                mon_sp     = sync_pulse;
                mon_dv     = dout_valid;
                mon_err    = err_sync;
                mon_dout   = dout;
                mon_locked = locked;
            end
            if (toggle) begin
                step(1'($urandom % 2), 1'b0);
                if (sync_pulse | dout_valid | err_sync) mon_early = 1'b1;
            end
        end
        got = {mon_early, mon_sp, mon_dv, mon_err, mon_locked};
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sin    = 1'($urandom % 2);
            sin_en = 1'($urandom % 2);
            @(posedge clk);
            #1;
            checks++;
            if ({dout, dout_valid, sync_pulse, err_sync, locked} !== 8'h00) begin
                errors++;
                $display("FAIL reset cyc%0d: outputs=%b required 00000000", i,
                         {dout, dout_valid, sync_pulse, err_sync, locked});
            end
        end
        rst_n = 1'b0;
    endtask

    task automatic test_lock(input bit toggle);
        do_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1);
            if (toggle) step(1'b1, 1'b0);
        end
        for (int f = 0; f < 4; f++) begin
            send_word(4'b1011, toggle);
            exp = {1'b0, 1'b1, 1'b0, 1'b0, (f >= 1)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL lock(t=%0d) f%0d sync: status=%b required %b", toggle, f, got, exp);
            end
            for (int d = 1; d <= 3; d++) begin
                send_word(4'(d), toggle);
                exp = {1'b0, 1'b0, (f >= 1), 1'b0, (f >= 1)};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL lock(t=%0d) f%0d data%0d: status=%b required %b", toggle, f, d, got, exp);
                end
                if (f >= 1) begin
                    checks++;
                    if (mon_dout !== 4'(d)) begin
                        errors++;
                        $display("FAIL lock(t=%0d) f%0d dout: got %h required %h", toggle, f, mon_dout, 4'(d));
                    end
                end
            end
        end
    endtask

    // Runs from the locked state left by test_lock.
    task automatic test_flywheel();
        logic [3:0] syncs [4];
        logic [4:0] sync_exp [4];
        logic       dv_exp [4];
        syncs[0] = 4'b1010; sync_exp[0] = 5'b00011; dv_exp[0] = 1'b1;
        syncs[1] = 4'b1011; sync_exp[1] = 5'b01001; dv_exp[1] = 1'b1;
        syncs[2] = 4'b1010; sync_exp[2] = 5'b00011; dv_exp[2] = 1'b1;
        syncs[3] = 4'b1010; sync_exp[3] = 5'b00010; dv_exp[3] = 1'b0;
        for (int f = 0; f < 4; f++) begin
            send_word(syncs[f], 1'b0);
            checks++;
            if (got !== sync_exp[f]) begin
                errors++;
                $display("FAIL flywheel f%0d sync: status=%b required %b", f, got, sync_exp[f]);
            end
            for (int d = 1; d <= 3; d++) begin
                send_word(4'(d), 1'b0);
                exp = {1'b0, 1'b0, dv_exp[f], 1'b0, dv_exp[f]};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL flywheel f%0d data%0d: status=%b required %b", f, d, got, exp);
                end
                if (dv_exp[f]) begin
                    checks++;
                    if (mon_dout !== 4'(d)) begin
                        errors++;
                        $display("FAIL flywheel f%0d dout: got %h required %h", f, mon_dout, 4'(d));
                    end
                end
            end
        end
    endtask

    task automatic test_verify_fail();
        logic [3:0] syncs [3];
        logic [4:0] sync_exp [3];
        syncs[0] = 4'b1011; sync_exp[0] = 5'b01000;
        syncs[1] = 4'b0011; sync_exp[1] = 5'b00000;
        // Only a hunt-state hit (good count restarting at 1) keeps locked low here.
        syncs[2] = 4'b1011; sync_exp[2] = 5'b01000;
        do_reset();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        for (int f = 0; f < 3; f++) begin
            send_word(syncs[f], 1'b0);
            checks++;
            if (got !== sync_exp[f]) begin
                errors++;
                $display("FAIL verify_fail f%0d sync: status=%b required %b", f, got, sync_exp[f]);
            end
            for (int d = 1; d <= 3; d++) begin
                send_word(4'(d), 1'b0);
                checks++;
                if (got !== 5'b00000) begin
                    errors++;
                    $display("FAIL verify_fail f%0d data%0d: status=%b required 00000", f, d, got);
                end
            end
        end
    endtask

    task automatic test_midword_reset();
        do_reset();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        for (int f = 0; f < 2; f++) begin
            send_word(4'b1011, 1'b0);
            for (int d = 1; d <= 3; d++) send_word(4'(d), 1'b0);
        end
        checks++;
        if ({mon_dout, mon_locked} !== 5'b00111) begin
            errors++;
            $display("FAIL midreset prelock: dout,locked=%b required 00111", {mon_dout, mon_locked});
        end
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        rst_n  = 1'b1;
        sin    = 1'b1;
        sin_en = 1'b1;
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        checks++;
        if ({dout, dout_valid, sync_pulse, err_sync, locked} !== 8'h00) begin
            errors++;
            $display("FAIL midreset clear: outputs=%b required 00000000",
                     {dout, dout_valid, sync_pulse, err_sync, locked});
        end
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        for (int f = 0; f < 2; f++) begin
            send_word(4'b1011, 1'b0);
            exp = {1'b0, 1'b1, 1'b0, 1'b0, (f == 1)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL midreset relock f%0d sync: status=%b required %b", f, got, exp);
            end
            for (int d = 1; d <= 3; d++) begin
                send_word(4'(d), 1'b0);
                exp = {1'b0, 1'b0, (f == 1), 1'b0, (f == 1)};
                checks++;
                if ({got, mon_dout} !== {exp, (f == 1) ? 4'(d) : 4'h0}) begin
                    errors++;
                    $display("FAIL midreset relock f%0d data%0d: status,dout=%b required %b", f, d,
                             {got, mon_dout}, {exp, (f == 1) ? 4'(d) : 4'h0});
                end
            end
        end
    endtask

    initial begin
        rst_n  = 1'b1;
        sin    = 1'b0;
        sin_en = 1'b0;
        test_reset();
        test_lock(1'b0);
        test_lock(1'b1);
        test_flywheel();
        test_verify_fail();
        test_midword_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
